// File: rtl/lc3_int_pkg.sv
// Shared types and constants for the LC-3 interrupt/exception entry sequencer.
package lc3_int_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SWAP,
      ST_PUSH_PSR,
      ST_PUSH_PC,
      ST_READ_TBL,
      ST_FINISH
   } state_t;

   localparam logic [1:0] VM_DEV  = 2'b00;
   localparam logic [1:0] VM_PRIV = 2'b01;
   localparam logic [1:0] VM_OPC  = 2'b10;

   localparam int PSR_U     = 15;
   localparam int PSR_PL_HI = 10;
   localparam int PSR_PL_LO = 8;

   localparam logic [7:0] VEC_PRIV = 8'h00;
   localparam logic [7:0] VEC_OPC  = 8'h01;

endpackage

// File: rtl/int_arbiter.sv
// Combinational choice between opcode exception, privilege exception and
// device interrupt at an instruction boundary.
module int_arbiter
   import lc3_int_pkg::*;
(
   input  logic       instr_boundary,
   input  logic [2:0] int_priority,
   input  logic       priv_exc,
   input  logic       opc_exc,
   input  logic [2:0] cur_pl,
   output logic       accept,
   output logic [1:0] vector_mux,
   output logic [2:0] new_pl
);

   always_comb begin
      accept     = 1'b0;
      vector_mux = VM_DEV;
      new_pl     = cur_pl;
      if (opc_exc) begin
         accept     = instr_boundary;
         vector_mux = VM_OPC;
      end else if (priv_exc) begin
         accept     = instr_boundary;
         vector_mux = VM_PRIV;
      end else if (int_priority > cur_pl) begin
         // priority 0 can never exceed a level, so "no request" is never taken
         accept     = instr_boundary;
         new_pl     = int_priority;
      end
   end

endmodule

// File: rtl/int_entry_seq.sv
// LC-3 interrupt/exception entry: stack swap, push PSR and PC, fetch the
// service address from the vector table, then load PC, R6 and PSR together.
module int_entry_seq
   import lc3_int_pkg::*;
#(
   parameter int            DW         = 16,
   parameter logic [DW-1:0] TABLE_BASE = 16'h0100
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          instr_boundary,
   input  logic [2:0]    int_priority,
   input  logic          priv_exc,
   input  logic          opc_exc,
   input  logic [7:0]    vector,
   output logic [1:0]    vector_mux,
   output logic          ld_vector,
   input  logic [DW-1:0] psr,
   input  logic [DW-1:0] pc,
   input  logic [DW-1:0] r6,
   input  logic [DW-1:0] saved_ssp,
   output logic          mem_req,
   output logic          mem_we,
   output logic [DW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic [DW-1:0] saved_usp_out,
   output logic          ld_saved_usp,
   output logic [DW-1:0] r6_out,
   output logic          ld_r6,
   output logic [DW-1:0] psr_out,
   output logic          ld_psr,
   output logic [DW-1:0] pc_out,
   output logic          ld_pc,
   output logic          busy
);

   localparam logic [DW-1:0] ONE = 1;
   localparam logic [DW-1:0] TWO = 2;

   state_t        state, state_nxt;
   logic [DW-1:0] sp, psr_snap, pc_snap, tgt, psr_new;
   logic [2:0]    pl_snap;

   logic          arb_boundary, accept;
   logic [1:0]    arb_mux;
   logic [2:0]    arb_pl;

   assign arb_boundary = instr_boundary && (state == ST_IDLE) && !reset;

   int_arbiter u_arb (
      .instr_boundary (arb_boundary),
      .int_priority   (int_priority),
      .priv_exc       (priv_exc),
      .opc_exc        (opc_exc),
      .cur_pl         (psr[PSR_PL_HI:PSR_PL_LO]),
      .accept         (accept),
      .vector_mux     (arb_mux),
      .new_pl         (arb_pl)
   );

   always_comb begin
      psr_new                      = psr_snap;
      psr_new[PSR_U]               = 1'b0;
      psr_new[PSR_PL_HI:PSR_PL_LO] = pl_snap;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         sp       <= '0;
         psr_snap <= '0;
         pc_snap  <= '0;
         pl_snap  <= '0;
         tgt      <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && accept) begin
            psr_snap <= psr;
            pc_snap  <= pc;
            pl_snap  <= arb_pl;
         end
         if (state == ST_SWAP)
            sp <= psr_snap[PSR_U] ? saved_ssp : r6;
         if (state == ST_READ_TBL && mem_ready)
            tgt <= mem_rdata;
      end
   end

   always_comb begin
      state_nxt     = state;
      ld_vector     = 1'b0;
      vector_mux    = VM_DEV;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      saved_usp_out = '0;
      ld_saved_usp  = 1'b0;
      r6_out        = '0;
      ld_r6         = 1'b0;
      psr_out       = '0;
      ld_psr        = 1'b0;
      pc_out        = '0;
      ld_pc         = 1'b0;
      busy          = 1'b0;
      // while reset is held every output stays quiet, even mid-sequence
      if (!reset) begin
         busy = (state != ST_IDLE);
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  ld_vector  = 1'b1;
                  vector_mux = arb_mux;
                  state_nxt  = ST_SWAP;
               end
            end
            ST_SWAP: begin
               if (psr_snap[PSR_U]) begin
                  ld_saved_usp  = 1'b1;
                  saved_usp_out = r6;
               end
               state_nxt = ST_PUSH_PSR;
            end
            ST_PUSH_PSR: begin
               mem_req   = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = sp - ONE;
               mem_wdata = psr_snap;
               if (mem_ready) state_nxt = ST_PUSH_PC;
            end
            ST_PUSH_PC: begin
               mem_req   = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = sp - TWO;
               mem_wdata = pc_snap;
               if (mem_ready) state_nxt = ST_READ_TBL;
            end
            ST_READ_TBL: begin
               mem_req  = 1'b1;
               mem_addr = TABLE_BASE | {{(DW-8){1'b0}}, vector};
               if (mem_ready) state_nxt = ST_FINISH;
            end
            ST_FINISH: begin
               ld_pc     = 1'b1;
               pc_out    = tgt;
               ld_r6     = 1'b1;
               r6_out    = sp - TWO;
               ld_psr    = 1'b1;
               psr_out   = psr_new;
               state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_int_entry_seq.sv
// Self-checking bench for int_entry_seq: directed table, random entries against
// a rule-level model, plus wait-state, reset-abort and idle-ready sequences.
module tb_int_entry_seq;

   logic        clk = 1'b0;
   logic        reset, instr_boundary, priv_exc, opc_exc, mem_ready;
   logic [2:0]  int_priority;
   logic [7:0]  vector;
   logic [15:0] psr, pc, r6, saved_ssp, mem_rdata;
   logic [1:0]  vector_mux;
   logic        ld_vector, mem_req, mem_we, ld_saved_usp, ld_r6, ld_psr, ld_pc, busy;
   logic [15:0] mem_addr, mem_wdata, saved_usp_out, r6_out, psr_out, pc_out;
   logic        out_nz;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   int_entry_seq dut (
      .clk(clk), .reset(reset), .instr_boundary(instr_boundary),
      .int_priority(int_priority), .priv_exc(priv_exc), .opc_exc(opc_exc),
      .vector(vector), .vector_mux(vector_mux), .ld_vector(ld_vector),
      .psr(psr), .pc(pc), .r6(r6), .saved_ssp(saved_ssp),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .saved_usp_out(saved_usp_out), .ld_saved_usp(ld_saved_usp),
      .r6_out(r6_out), .ld_r6(ld_r6), .psr_out(psr_out), .ld_psr(ld_psr),
      .pc_out(pc_out), .ld_pc(ld_pc), .busy(busy)
   );

   assign out_nz = |{vector_mux, ld_vector, mem_req, mem_we, mem_addr, mem_wdata,
                     saved_usp_out, ld_saved_usp, r6_out, ld_r6, psr_out, ld_psr,
                     pc_out, ld_pc, busy};

   typedef struct {
      logic [15:0] psr, pc, r6, ssp;
      logic [2:0]  prio;
      logic        priv, opc;
      logic [7:0]  vec;
      logic [15:0] rd;
      int          waits;
      logic        e_acc;
      logic [1:0]  e_mux;
      logic [15:0] e_r6, e_psr;
   } vec_t;

   vec_t tbl[8];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Expected outcome straight from the architectural entry rules.
   function automatic vec_t ref_model(input vec_t v);
      vec_t        r = v;
      logic [2:0]  pl = v.psr[10:8];
      logic [2:0]  np;
      r.e_acc = v.opc || v.priv || (v.prio > pl);
      r.e_mux = v.opc ? 2'b10 : (v.priv ? 2'b01 : 2'b00);
      np      = (v.opc || v.priv) ? pl : v.prio;
      r.e_r6  = (v.psr[15] ? v.ssp : v.r6) - 16'd2;
      r.e_psr = (v.psr & 16'h78FF) | {5'b0, np, 8'h00};
      if (!r.e_acc) begin
         r.e_r6  = '0;
         r.e_psr = '0;
      end
      return r;
   endfunction

   task automatic do_entry(input string nm, input vec_t v);
      logic [15:0] spx;
      logic [15:0] aa[3];
      logic [15:0] ad[3];
      logic        aw[3];
      int          na = 0, nusp = 0, unstable = 0, bad = 0, fin_cyc = -1, wl = 0;
      logic [15:0] uspv = '0, c_addr = '0, c_wd = '0, o_pc = '0, o_r6 = '0, o_psr = '0;
      logic        in_acc = 1'b0, c_we = 1'b0;
      @(negedge clk);
      psr = v.psr; pc = v.pc; r6 = v.r6; saved_ssp = v.ssp;
      int_priority = v.prio; priv_exc = v.priv; opc_exc = v.opc;
      instr_boundary = 1'b1; mem_ready = 1'b0;
      #1;
      chk({nm, " ld_vector"}, 16'(ld_vector), 16'(v.e_acc));
      if (!v.e_acc) begin
         @(negedge clk);
         instr_boundary = 1'b0;
         #1;
         chk({nm, " not busy"}, 16'(busy), 16'd0);
         return;
      end
      chk({nm, " vector_mux"}, 16'(vector_mux), 16'(v.e_mux));
      spx = v.psr[15] ? v.ssp : v.r6;
      for (int cyc = 0; cyc < 60 && fin_cyc < 0; cyc++) begin
         @(negedge clk);
         instr_boundary = 1'($urandom); int_priority = 3'($urandom);
         priv_exc = 1'($urandom); opc_exc = 1'($urandom);
         psr = 16'($urandom); pc = 16'($urandom); vector = v.vec;
         if (cyc > 0) r6 = 16'($urandom);
         mem_ready = 1'b0; mem_rdata = 16'($urandom);
         #1;
         if (!busy || ld_vector) bad++;
         if (ld_saved_usp) begin nusp++; uspv = saved_usp_out; end
         if (ld_pc && ld_r6 && ld_psr) begin
            fin_cyc = cyc; o_pc = pc_out; o_r6 = r6_out; o_psr = psr_out;
         end else if (ld_pc || ld_r6 || ld_psr) bad++;
         if (mem_req) begin
            if (!in_acc) begin
               in_acc = 1'b1; c_addr = mem_addr; c_we = mem_we; c_wd = mem_wdata; wl = v.waits;
            end else if (mem_addr !== c_addr || mem_we !== c_we || mem_wdata !== c_wd) unstable++;
            if (wl == 0) begin
               mem_ready = 1'b1;
               if (!c_we) mem_rdata = v.rd;
               if (na < 3) begin aa[na] = c_addr; ad[na] = c_wd; aw[na] = c_we; end
               na++;
               in_acc = 1'b0;
            end else wl--;
         end else mem_ready = 1'($urandom);
      end
      chk({nm, " finish cycle"}, 16'(fin_cyc), 16'(4 + 3 * v.waits));
      chk({nm, " usp strobes"}, 16'(nusp), 16'(v.psr[15]));
      chk({nm, " usp value"}, uspv, v.psr[15] ? v.r6 : 16'h0000);
      chk({nm, " access count"}, 16'(na), 16'd3);
      chk({nm, " push psr addr"}, aa[0], 16'(spx - 16'd1));
      chk({nm, " push psr data"}, ad[0], v.psr);
      chk({nm, " push psr we"}, 16'(aw[0]), 16'd1);
      chk({nm, " push pc addr"}, aa[1], 16'(spx - 16'd2));
      chk({nm, " push pc data"}, ad[1], v.pc);
      chk({nm, " push pc we"}, 16'(aw[1]), 16'd1);
      chk({nm, " table addr"}, aa[2], 16'h0100 | {8'h00, v.vec});
      chk({nm, " table we"}, 16'(aw[2]), 16'd0);
      chk({nm, " pc_out"}, o_pc, v.rd);
      chk({nm, " r6_out"}, o_r6, v.e_r6);
      chk({nm, " psr_out"}, o_psr, v.e_psr);
      chk({nm, " held stable"}, 16'(unstable), 16'd0);
      chk({nm, " stray strobes"}, 16'(bad), 16'd0);
      @(negedge clk);
      instr_boundary = 1'b0; priv_exc = 1'b0; opc_exc = 1'b0; int_priority = 3'd0; mem_ready = 1'b0;
      #1;
      chk({nm, " idle after"}, 16'(out_nz), 16'd0);
   endtask

   initial begin
      logic found;
      int   nld;
      vec_t rv;
      reset = 1'b1; instr_boundary = 1'b0; int_priority = 3'd0; priv_exc = 1'b0;
      opc_exc = 1'b0; vector = 8'h00; psr = '0; pc = '0; r6 = '0; saved_ssp = '0;
      mem_rdata = '0; mem_ready = 1'b0;

      tbl[0] = '{16'h8002, 16'h3050, 16'h3000, 16'h3000, 3'd2, 1'b0, 1'b0, 8'h02, 16'h1234, 0, 1'b1, 2'b00, 16'h2FFE, 16'h0202};
      tbl[1] = '{16'h0400, 16'h3100, 16'h2000, 16'h4000, 3'd2, 1'b0, 1'b0, 8'h02, 16'h5555, 0, 1'b0, 2'b00, 16'h0000, 16'h0000};
      tbl[2] = '{16'h0100, 16'h3100, 16'h2000, 16'h4000, 3'd2, 1'b0, 1'b0, 8'h02, 16'h5555, 0, 1'b1, 2'b00, 16'h1FFE, 16'h0200};
      tbl[3] = '{16'h8102, 16'h3200, 16'h1000, 16'h3000, 3'd2, 1'b1, 1'b1, 8'h01, 16'h0777, 0, 1'b1, 2'b10, 16'h2FFE, 16'h0102};
      tbl[4] = '{16'h0000, 16'h3300, 16'h0000, 16'h7000, 3'd0, 1'b1, 1'b0, 8'h00, 16'h0ABC, 0, 1'b1, 2'b01, 16'hFFFE, 16'h0000};
      tbl[5] = '{16'h8407, 16'h3400, 16'h6000, 16'h5000, 3'd7, 1'b0, 1'b0, 8'h80, 16'h4321, 3, 1'b1, 2'b00, 16'h4FFE, 16'h0707};
      tbl[6] = '{16'h0300, 16'h3500, 16'h2000, 16'h4000, 3'd3, 1'b0, 1'b0, 8'h03, 16'h1111, 0, 1'b0, 2'b00, 16'h0000, 16'h0000};
      tbl[7] = '{16'h0000, 16'h3600, 16'h2000, 16'h4000, 3'd0, 1'b0, 1'b0, 8'h04, 16'h2222, 0, 1'b0, 2'b00, 16'h0000, 16'h0000};

      repeat (3) @(negedge clk);
      #1;
      chk("reset outputs", 16'(out_nz), 16'd0);
      reset = 1'b0;
      @(negedge clk);
      #1;
      chk("post-reset idle", 16'(out_nz), 16'd0);

      for (int i = 0; i < 8; i++)
         do_entry($sformatf("tbl%0d", i), tbl[i]);

      for (int i = 0; i < 25; i++) begin
         rv.psr = 16'($urandom); rv.pc = 16'($urandom); rv.r6 = 16'($urandom);
         rv.ssp = 16'($urandom); rv.prio = 3'($urandom);
         rv.priv = ($urandom_range(0, 5) == 0); rv.opc = ($urandom_range(0, 5) == 0);
         rv.vec = 8'($urandom); rv.rd = 16'($urandom); rv.waits = $urandom_range(0, 2);
         do_entry($sformatf("rnd%0d", i), ref_model(rv));
      end

      // mem_ready and requests without an instruction boundary do nothing
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         instr_boundary = 1'b0; opc_exc = 1'b1; priv_exc = 1'b1; int_priority = 3'd7;
         psr = 16'h0000; mem_ready = 1'b1;
         #1;
         chk($sformatf("idle ready %0d", i), 16'(out_nz), 16'd0);
      end

      // reset while the vector table read is stalled
      @(negedge clk);
      opc_exc = 1'b0; priv_exc = 1'b0; int_priority = 3'd2; psr = 16'h8002;
      pc = 16'h3050; r6 = 16'h3000; saved_ssp = 16'h3000; instr_boundary = 1'b1; mem_ready = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
         @(negedge clk);
         instr_boundary = 1'b0; int_priority = 3'd0; vector = 8'h05; mem_ready = 1'b0;
         #1;
         if (mem_req && !mem_we) found = 1'b1;
         else if (mem_req) mem_ready = 1'b1;
      end
      chk("abort reached table read", 16'(found), 16'd1);
      reset = 1'b1; mem_ready = 1'b1; mem_rdata = 16'hDEAD;
      @(negedge clk);
      reset = 1'b0; mem_ready = 1'b0;
      #1;
      chk("abort outputs zero", 16'(out_nz), 16'd0);
      nld = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         mem_ready = 1'($urandom);
         #1;
         if (ld_pc || ld_r6 || ld_psr || busy || mem_req) nld++;
      end
      chk("abort no late strobes", 16'(nld), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/int_entry_seq.md
Name: int_entry_seq

Overview:
- CPU-side consumer of the interrupt controller's priority/vector outputs. It arbitrates pending interrupts and exceptions at instruction boundaries and drives the controller's vector load (VectorMUX/LD_Vector).
- It runs the LC-3 entry sequence: stack swap, push PSR, push PC, then fetch the service address from the vector table. It then loads PC, R6 and PSR.
- It sits between the INT controller, the datapath register file/PSR, and the memory port.

Parameters:
- TABLE_BASE, 16'h0100, base address of the interrupt/exception vector table.
- DW, 16, datapath/address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- instr_boundary  in  1  high in a cycle where a new instruction may be fetched.
- int_priority  in  3  pending device priority from interrupt controller (0 = none).
- priv_exc  in  1  privilege-mode violation from decode.
- opc_exc  in  1  illegal-opcode exception from decode.
- vector  in  8  latched vector from interrupt controller; valid the cycle after ld_vector.
- vector_mux  out  2  vector source select: 00 device, 01 priv exc, 10 opcode exc.
- ld_vector  out  1  one-cycle vector latch strobe to the controller.
- psr  in  DW  current PSR: [15] user mode, [10:8] priority level, [2:0] NZP.
- pc  in  DW  PC of the next instruction (return address).
- r6  in  DW  current R6.
- saved_ssp  in  DW  saved supervisor stack pointer.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write.
- mem_addr  out  DW  memory address.
- mem_wdata  out  DW  write data.
- mem_rdata  in  DW  read data, valid with mem_ready.
- mem_ready  in  1  access completes this cycle.
- saved_usp_out  out  DW  value for Saved_USP.
- ld_saved_usp  out  1  Saved_USP load strobe.
- r6_out  out  DW  new R6.
- ld_r6  out  1  R6 load strobe.
- psr_out  out  DW  new PSR.
- ld_psr  out  1  PSR load strobe.
- pc_out  out  DW  new PC.
- ld_pc  out  1  PC load strobe.
- busy  out  1  sequence in progress; fetch must stall.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; snapshot registers 0.
- Reset mid-sequence: on the next edge go to IDLE, drop mem_req, and emit no ld_* strobe.
- Acceptance (IDLE only): start when instr_boundary=1 and any of the following holds:
  - opc_exc=1;
  - priv_exc=1;
  - int_priority > psr[10:8] (unsigned compare).
- Acceptance priority: opc_exc > priv_exc > interrupt. int_priority=0 is never accepted.
- Accept cycle actions:
  - ld_vector=1 with vector_mux per the winning source; busy=1 from the next cycle.
  - Snapshot psr and pc.
  - new_pl = int_priority for an interrupt, psr[10:8] for an exception.
- States:
  - IDLE: acceptance check as above.
  - SWAP:
    - If psr_snap[15]=1: ld_saved_usp=1, saved_usp_out=r6, sp<=saved_ssp.
    - Else: sp<=r6.
    - Always 1 cycle.
  - PUSH_PSR: mem_req=1, mem_we=1, mem_addr=sp-1, mem_wdata=psr_snap. Advance on mem_ready.
  - PUSH_PC: mem_req=1, mem_we=1, mem_addr=sp-2, mem_wdata=pc_snap. Advance on mem_ready.
  - READ_TBL: mem_req=1, mem_we=0, mem_addr=TABLE_BASE | {8'h00,vector}. On mem_ready, capture mem_rdata into tgt and advance.
  - FINISH (1 cycle): all strobes together:
    - ld_pc=1, pc_out=tgt;
    - ld_r6=1, r6_out=sp-2;
    - ld_psr=1, psr_out=psr_snap with [15]=0 and [10:8]=new_pl, other bits kept.
    - Then go to IDLE; busy=0 in the next cycle.
- Memory handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable until the cycle mem_ready=1.
  - mem_ready while mem_req=0 is ignored.
  - Zero-wait memory gives accept-to-FINISH = 5 cycles.
- Stack arithmetic is modulo 2^DW: sp=16'h0000 pushes to 16'hFFFF and 16'hFFFE.
- Inputs while busy: int_priority, priv_exc and opc_exc are ignored. psr, pc and r6 changes have no effect after the snapshot.
- ld_* strobes are single-cycle pulses, never asserted outside SWAP/FINISH.

Decomposition:
- Shared package `lc3_int_pkg`:
  - state enum;
  - vector_mux encodings VM_DEV=2'b00, VM_PRIV=2'b01, VM_OPC=2'b10;
  - PSR field indices (PSR_U=15, PSR_PL=10:8);
  - vector constants 8'h00 and 8'h01.
- Natural sub-module `int_arbiter`: combinational acceptance/priority decision producing accept, vector_mux and new_pl.

Test Plan:
- User mode, psr=16'h8002, r6=16'h3000, saved_ssp=16'h3000, int_priority=3'b010, vector=8'h02, zero-wait memory:
  - ld_vector with vector_mux=00;
  - ld_saved_usp with 16'h3000;
  - writes M[2FFF]=8002 and M[2FFE]=pc;
  - reads 0102 returning 1234;
  - ld_pc=1234, r6_out=2FFE, psr_out=16'h0202.
- Supervisor mode, psr=16'h0400 (PL4), int_priority=3'b010: never accepted. Raising psr to PL1: accepted; no ld_saved_usp, sp=r6.
- opc_exc=1 and priv_exc=1 together with int_priority=3'b010 at the boundary:
  - vector_mux=10, table address 16'h0101;
  - psr_out PL unchanged, [15]=0.
- mem_ready held low 3 cycles in PUSH_PC: mem_addr and mem_wdata stable, no strobes, then normal completion. Extra mem_ready in IDLE causes no action.
- reset asserted during READ_TBL: next cycle all outputs 0 and busy=0; no ld_pc/ld_r6/ld_psr observed.
- r6=16'h0000, supervisor mode: push addresses 16'hFFFF and 16'hFFFE; r6_out=16'hFFFE.
